multicycle_main_controller: RTL and testbench

- Moore/Mealy FSM control unit for the multi-cycle MIPS datapath. It is the successor to the single-cycle opcode decoder.
- Sequences each instruction over 3–5 cycles and stretches memory states with a ready handshake.
- Optionally supports bne and reports illegal opcodes.
- Keeps a retired-instruction counter for the debug/perf path.

---
 rtl/multicycle_main_controller.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_main_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// multicycle_main_controller
//
// Control FSM for the multi-cycle MIPS datapath. Each instruction is sequenced
// over 3-5 cycles. FETCH, MEMRD and MEMWR wait for mem_ready. Optional bne
// support is available. Unsupported opcodes raise a one-cycle illegal pulse.
// A retired-instruction counter is kept for the debug/perf path.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   opcode[5:0]     inst[31:26] from the IR (meaningful from DECODE onward)
//   mem_ready       memory finishes the current access this cycle
//   pc_write, pc_write_cond, branch_ne, pc_src[1:0]   PC update control
//   i_or_d, mem_read, mem_write, ir_write             memory interface control
//   mem_to_reg, reg_dst, reg_write                    register-file writeback
//   alu_src_a, alu_src_b[1:0], alu_op[ALUOP_W-1:0]    ALU operand/op select
//   illegal         one-cycle pulse for an unsupported opcode
//   instr_done      one-cycle pulse in the last cycle of each instruction
//   instr_count     retired instructions (wraps)
//   state[3:0]      current state, for debug
// -----------------------------------------------------------------------------
module multicycle_main_controller #(
  parameter int ALUOP_W     = 2,
  parameter bit SUPPORT_BNE = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_count,
  output logic [3:0]         state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_ADDI_EX  = 4'd8;
  localparam logic [3:0] S_ADDI_WB  = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_RTYPE_EX;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_ADDI:       state_d = S_ADDI_EX;
          OP_BEQ:        state_d = S_BRANCH;
          OP_BNE:        state_d = SUPPORT_BNE ? S_BRANCH : S_ILLEGAL;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything other than lw is a store.
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;   // all one-cycle tails and 13-15
    endcase
  end

  // Output logic. Every output is held at 0 while reset is asserted,
  // so an aborted instruction cannot issue any partial write.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_src        = 2'b00;
    illegal       = 1'b0;
    instr_done    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;   // IR and PC+4 commit only when the fetch completes
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_RTYPE_EX: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_RTYPE_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          branch_ne     = (opcode == OP_BNE);
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        S_ILLEGAL: begin
          illegal = 1'b1;          // not retired: instr_done stays low
        end
        default: ;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt_q <= '0;
    else if (instr_done) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_controller
//
// Two controller instances share clk and rst_n: dut_a with default parameters,
// dut_b with SUPPORT_BNE=0 and CNT_W=2. The reference model expands each
// instruction into the expected per-cycle list of (state, mem_ready, outputs).
// It does this from the instruction class and the wait counts. The active DUT
// is then stepped through that list while the idle DUT sits in FETCH with
// mem_ready low.
// -----------------------------------------------------------------------------
module tb_multicycle_main_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_a, op_b;
  logic       rdy_a, rdy_b;

  logic        a_pcw, a_pcwc, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca, a_ill, a_done;
  logic [1:0]  a_srcb, a_aluop, a_pcsrc;
  logic [31:0] a_cnt;
  logic [3:0]  a_state;
  logic        b_pcw, b_pcwc, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca, b_ill, b_done;
  logic [1:0]  b_srcb, b_aluop, b_pcsrc;
  logic [1:0]  b_cnt;
  logic [3:0]  b_state;

  always #5 clk = ~clk;

  multicycle_main_controller dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(op_a), .mem_ready(rdy_a),
    .pc_write(a_pcw), .pc_write_cond(a_pcwc), .branch_ne(a_bne), .i_or_d(a_iord),
    .mem_read(a_mrd), .mem_write(a_mwr), .ir_write(a_irw), .mem_to_reg(a_m2r),
    .reg_dst(a_rdst), .reg_write(a_rw), .alu_src_a(a_srca), .alu_src_b(a_srcb),
    .alu_op(a_aluop), .pc_src(a_pcsrc), .illegal(a_ill), .instr_done(a_done),
    .instr_count(a_cnt), .state(a_state));

  multicycle_main_controller #(.ALUOP_W(2), .SUPPORT_BNE(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(op_b), .mem_ready(rdy_b),
    .pc_write(b_pcw), .pc_write_cond(b_pcwc), .branch_ne(b_bne), .i_or_d(b_iord),
    .mem_read(b_mrd), .mem_write(b_mwr), .ir_write(b_irw), .mem_to_reg(b_m2r),
    .reg_dst(b_rdst), .reg_write(b_rw), .alu_src_a(b_srca), .alu_src_b(b_srcb),
    .alu_op(b_aluop), .pc_src(b_pcsrc), .illegal(b_ill), .instr_done(b_done),
    .instr_count(b_cnt), .state(b_state));

  // Output vector layout: pcw pcwc bne iord mrd mwr irw m2r rdst rw srca srcb[2] aluop[2] pcsrc[2] ill done
  logic [18:0] out_a, out_b;
  assign out_a = {a_pcw, a_pcwc, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw,
                  a_srca, a_srcb, a_aluop, a_pcsrc, a_ill, a_done};
  assign out_b = {b_pcw, b_pcwc, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw,
                  b_srca, b_srcb, b_aluop, b_pcsrc, b_ill, b_done};

  localparam logic [18:0] PCW  = 19'h1 << 18, PCWC = 19'h1 << 17, BNE  = 19'h1 << 16;
  localparam logic [18:0] IORD = 19'h1 << 15, MRD  = 19'h1 << 14, MWR  = 19'h1 << 13;
  localparam logic [18:0] IRW  = 19'h1 << 12, M2R  = 19'h1 << 11, RDST = 19'h1 << 10;
  localparam logic [18:0] RW   = 19'h1 << 9,  SRCA = 19'h1 << 8,  ILL  = 19'h1 << 1;
  localparam logic [18:0] DONE = 19'h1;

  function automatic logic [18:0] srcb(input int v);  return 19'(v & 3) << 6; endfunction
  function automatic logic [18:0] aluop(input int v); return 19'(v & 3) << 4; endfunction
  function automatic logic [18:0] pcsrc(input int v); return 19'(v & 3) << 2; endfunction

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] BEQ = 6'b000100, BNEOP = 6'b000101, JMP = 6'b000010;

  typedef struct packed {
    logic [3:0]  st;
    logic        rdy;
    logic [18:0] ex;
  } cyc_t;

  cyc_t plan[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_a_m = 0;
  int   cnt_b_m = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int st, input logic rdy, input logic [18:0] ex);
    cyc_t c;
    c.st = 4'(st); c.rdy = rdy; c.ex = ex;
    plan.push_back(c);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom & 1);
  endfunction

  // Expand one instruction into its expected cycle list.
  task automatic build(input logic [5:0] op, input int fw, input int mw, input bit bne_ok);
    plan.delete();
    for (int i = 0; i < fw; i++) push(0, 1'b0, MRD | srcb(1));
    push(0, 1'b1, MRD | srcb(1) | IRW | PCW);
    push(1, rnd_bit(), srcb(3));
    if (op == LW) begin
      push(2, rnd_bit(), SRCA | srcb(2));
      for (int i = 0; i < mw; i++) push(3, 1'b0, MRD | IORD);
      push(3, 1'b1, MRD | IORD);
      push(4, rnd_bit(), RW | M2R | DONE);
    end else if (op == SW) begin
      push(2, rnd_bit(), SRCA | srcb(2));
      for (int i = 0; i < mw; i++) push(5, 1'b0, MWR | IORD);
      push(5, 1'b1, MWR | IORD | DONE);
    end else if (op == RT) begin
      push(6, rnd_bit(), SRCA | aluop(2));
      push(7, rnd_bit(), RW | RDST | DONE);
    end else if (op == ADDI) begin
      push(8, rnd_bit(), SRCA | srcb(2));
      push(9, rnd_bit(), RW | DONE);
    end else if (op == BEQ || (op == BNEOP && bne_ok)) begin
      push(10, rnd_bit(), SRCA | aluop(1) | PCWC | pcsrc(1) | DONE | ((op == BNEOP) ? BNE : 19'h0));
    end else if (op == JMP) begin
      push(11, rnd_bit(), PCW | pcsrc(2) | DONE);
    end else begin
      push(12, rnd_bit(), ILL);
    end
  endtask

  // Step the selected DUT through one instruction. Entered and left at posedge+1.
  task automatic run_instr(input bit use_b, input logic [5:0] op, input int fw, input int mw,
                           input bit abort_wb);
    build(op, fw, mw, !use_b);
    foreach (plan[i]) begin
      cyc_t c;
      logic [5:0] drv;
      c = plan[i];
      drv = (c.st == 4'd0) ? 6'($urandom) : op;
      if (use_b) begin op_b = drv; rdy_b = c.rdy; end
      else       begin op_a = drv; rdy_a = c.rdy; end
      if (abort_wb && c.st == 4'd4) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_state", {28'h0, a_state}, 32'h0);
        check_eq("abort_outs", {13'h0, out_a}, 32'h0);
        check_eq("abort_count", a_cnt, 32'h0);
        cnt_a_m = 0;
        cnt_b_m = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (use_b) begin
        check_eq($sformatf("b_state_c%0d", i), {28'h0, b_state}, {28'h0, c.st});
        check_eq($sformatf("b_outs_st%0d", c.st), {13'h0, out_b}, {13'h0, c.ex});
        check_eq("b_count", {30'h0, b_cnt}, 32'(cnt_b_m % 4));
      end else begin
        check_eq($sformatf("a_state_c%0d", i), {28'h0, a_state}, {28'h0, c.st});
        check_eq($sformatf("a_outs_st%0d", c.st), {13'h0, out_a}, {13'h0, c.ex});
        check_eq("a_count", a_cnt, 32'(cnt_a_m));
      end
      @(posedge clk);
      if (c.ex[0]) begin
        if (use_b) cnt_b_m++;
        else       cnt_a_m++;
      end
      #1;
    end
    if (use_b) rdy_b = 1'b0;
    else       rdy_a = 1'b0;
  endtask

  initial begin
    logic [5:0] ops[8];
    logic [5:0] bad[4];
    ops = '{LW, SW, RT, ADDI, BEQ, BNEOP, JMP, 6'b111111};
    bad = '{6'b111111, 6'b001100, 6'b000001, 6'b100000};

    rst_n = 1'b0; op_a = 6'h0; op_b = 6'h0; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state_a", {28'h0, a_state}, 32'h0);
    check_eq("rst_outs_a", {13'h0, out_a}, 32'h0);
    check_eq("rst_count_a", a_cnt, 32'h0);
    check_eq("rst_outs_b", {13'h0, out_b}, 32'h0);
    rdy_b = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed sequences from the plan
    run_instr(1'b0, LW, 0, 0, 1'b0);
    check_eq("lw_count", a_cnt, 32'd1);
    run_instr(1'b0, RT, 3, 0, 1'b0);
    run_instr(1'b0, BEQ, 0, 0, 1'b0);
    run_instr(1'b0, BNEOP, 0, 0, 1'b0);
    run_instr(1'b0, SW, 0, 2, 1'b0);
    run_instr(1'b0, 6'b111111, 0, 0, 1'b0);
    run_instr(1'b0, ADDI, 1, 0, 1'b0);
    run_instr(1'b0, JMP, 0, 0, 1'b0);
    check_eq("dir_count", a_cnt, 32'(cnt_a_m));
    run_instr(1'b0, LW, 0, 1, 1'b1);

    // Randomized instruction mix with random wait states
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      int fw, mw;
      op = ops[$urandom_range(0, 7)];
      if (op == 6'b111111) op = bad[$urandom_range(0, 3)];
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      mw = $urandom_range(0, 3);
      run_instr(1'b0, op, fw, mw, 1'b0);
    end
    check_eq("rand_count", a_cnt, 32'(cnt_a_m));

    // Instance without bne support and with a 2-bit counter
    run_instr(1'b1, BNEOP, 0, 0, 1'b0);
    check_eq("nobne_count", {30'h0, b_cnt}, 32'h0);
    for (int n = 0; n < 5; n++) run_instr(1'b1, JMP, $urandom_range(0, 1), 0, 1'b0);
    check_eq("wrap_count", {30'h0, b_cnt}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
